// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction prefetcher with redirect support.
//
// Issues in-order fetch requests starting at RESET_PC, tracks the PC of each
// outstanding request, and buffers returned words in a DEPTH-entry FIFO that
// feeds the processor. A redirect flushes the FIFO and retargets fetch; any
// responses still in flight for the old stream are counted and dropped
// (DRAIN) before fetching resumes.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   redirect_valid/redirect_pc   taken branch/jump and its target
//   mem_req_valid/addr/ready     fetch request handshake to instruction memory
//   mem_resp_valid/data          in-order fetch responses
//   instr_valid/data/pc/ready    FIFO head toward the processor
module instr_fetch_queue #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 mem_req_valid,
    output logic [WORD_SIZE-1:0] mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [WORD_SIZE-1:0] mem_resp_data,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]        out_q, out_d;
    logic [CW-1:0]        drop_q, drop_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;

    logic [WORD_SIZE-1:0] pc_mem   [DEPTH];
    logic [WORD_SIZE-1:0] data_mem [DEPTH];

    logic                 room, accept, resp_live, resp_keep, push, pop;
    logic [WORD_SIZE-1:0] resp_pc;
    logic                 unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credits cover both buffered words and requests still in flight, so a
    // response always has a free FIFO slot waiting for it.
    assign room          = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    assign mem_req_valid = rst && (state_q == FETCH) && room;
    assign mem_req_addr  = rst ? fetch_pc_q : RESET_PC;
    assign accept        = mem_req_valid && mem_req_ready;

    // A response with nothing in flight is stray and ignored.
    assign resp_live = mem_resp_valid && ((out_q != '0) || (drop_q != '0));
    // Old-stream responses are always older than live ones (in-order memory).
    assign resp_keep = resp_live && (drop_q == '0);
    assign push      = resp_keep && (state_q == FETCH) && !redirect_valid;
    assign pop       = instr_valid && instr_ready;

    // Requests are sequential, so the oldest live request sits out_q words
    // behind the next fetch address.
    assign resp_pc = fetch_pc_q - (WORD_SIZE'(out_q) << 2);

    assign instr_valid = rst && (cnt_q != '0);
    assign instr_data  = instr_valid ? data_mem[rd_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_q]   : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[WORD_SIZE-1:2], 2'b00};
            cnt_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
            out_d      = '0;
            // Everything in flight after this edge belongs to the old stream.
            drop_d     = CW'({1'b0, out_q} + {1'b0, drop_q}
                             + (CW+1)'(accept) - (CW+1)'(resp_live));
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
            out_d  = out_q + CW'(accept) - CW'(resp_keep);
            drop_d = drop_q - CW'(resp_live && (drop_q != '0));
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
            wr_d   = wr_q + AW'(push);
            rd_d   = rd_q + AW'(pop);
        end
        state_d = (drop_d != '0) ? DRAIN : FETCH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= resp_pc;
            data_mem[wr_q] <= mem_resp_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        w_valid, w_ivalid;
    logic [31:0] w_addr, w_idata, w_ipc;

    instr_fetch_queue #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    // Second instance only exercises the wrapping reset address.
    instr_fetch_queue #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_req_valid(w_valid), .mem_req_addr(w_addr),
        .mem_req_ready(1'b1),
        .mem_resp_valid(1'b0), .mem_resp_data(32'h0),
        .instr_valid(w_ivalid), .instr_data(w_idata),
        .instr_pc(w_ipc), .instr_ready(1'b0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] exp_pc[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: sample handshakes mid-cycle, then advance the memory model.
    task automatic cycle();
        logic acc, rsp, hs;
        logic [31:0] aa, hp, hd;
        @(negedge clk);
        acc = mem_req_valid && mem_req_ready;
        aa  = mem_req_addr;
        rsp = mem_resp_valid;
        hs  = instr_valid && instr_ready;
        hp  = instr_pc;
        hd  = instr_data;
        @(posedge clk);
        #1;
        if (hs) begin
            obs_pc.push_back(hp);
            obs_data.push_back(hd);
            obs_cyc.push_back(cyc);
        end
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (rsp && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (acc) begin
                acc_q.push_back(aa);
                mq_addr.push_back(aa);
                mq_due.push_back(cyc + lat);
            end
        end
        cyc++;
        if (rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = memfn(mq_addr[0]);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        obs_pc.delete();
        obs_data.delete();
        obs_cyc.delete();
        exp_pc.delete();
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        instr_ready    = 1'b0;
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
            checks++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_out data=%h pc=%h exp=0", instr_data, instr_pc); end
            checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", mem_req_addr); end
            checks++; if (w_addr !== 32'hFFFFFFF8) begin failures++; $display("FAIL reset_addr_wrap got=%h exp=fffffff8", w_addr); end
        end
        rst = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_after_reset got=%b exp=1", mem_req_valid); end
    endtask

    task automatic test_stream();
        int base;
        logic [31:0] e;
        do_reset();
        lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) exp_pc.push_back(32'(k * 4));
        base = cyc;
        repeat (12) cycle();
        checks++; if (obs_pc.size() != 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", obs_pc.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (acc_q.size() <= k || acc_q[k] !== 32'(k * 4)) begin failures++; $display("FAIL stream_req_addr idx=%0d exp=%h", k, 32'(k * 4)); end
        end
        for (int k = 0; k < obs_pc.size() && exp_pc.size() > 0; k++) begin
            e = exp_pc.pop_front();
            checks++; if (obs_pc[k] !== e || obs_data[k] !== memfn(e)) begin failures++; $display("FAIL stream_instr pc=%h data=%h exp_pc=%h exp_data=%h", obs_pc[k], obs_data[k], e, memfn(e)); end
            checks++; if (obs_cyc[k] !== base + 2 + k) begin failures++; $display("FAIL stream_timing idx=%0d got=%0d exp=%0d", k, obs_cyc[k] - base, 2 + k); end
        end
    endtask

    task automatic test_full();
        logic [31:0] e;
        do_reset();
        lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (10) cycle();
        checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL full_req_count got=%0d exp=4", acc_q.size()); end
        for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
            checks++; if (acc_q[k] !== 32'(k * 4)) begin failures++; $display("FAIL full_req_addr got=%h exp=%h", acc_q[k], 32'(k * 4)); end
        end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== memfn(32'h0)) begin failures++; $display("FAIL full_head v=%b pc=%h data=%h exp v=1 pc=0", instr_valid, instr_pc, instr_data); end
        for (int k = 0; k < 16; k++) exp_pc.push_back(32'(k * 4));
        instr_ready = 1'b1;
        repeat (8) cycle();
        checks++; if (obs_pc.size() < 5) begin failures++; $display("FAIL full_drain_count got=%0d exp>=5", obs_pc.size()); end
        for (int k = 0; k < obs_pc.size() && exp_pc.size() > 0; k++) begin
            e = exp_pc.pop_front();
            checks++; if (obs_pc[k] !== e || obs_data[k] !== memfn(e)) begin failures++; $display("FAIL full_drain_instr pc=%h exp=%h", obs_pc[k], e); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        do_reset();
        lat = 2; mem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (3) cycle();
        // Redirect while 4 and 8 are in flight, C is accepted and 4 answers.
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_drain_req0 got=%b exp=0", mem_req_valid); end
        clear_logs();
        instr_ready = 1'b1;
        cycle();
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_drain_req1 got=%b exp=0", mem_req_valid); end
        for (int k = 0; k < 8; k++) exp_pc.push_back(32'h100 + 32'(k * 4));
        repeat (14) cycle();
        checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin failures++; $display("FAIL redir_first_req exp=00000100 n=%0d", acc_q.size()); end
        checks++; if (obs_pc.size() < 4) begin failures++; $display("FAIL redir_count got=%0d exp>=4", obs_pc.size()); end
        for (int k = 0; k < obs_pc.size() && exp_pc.size() > 0; k++) begin
            e = exp_pc.pop_front();
            checks++; if (obs_pc[k] !== e || obs_data[k] !== memfn(e)) begin failures++; $display("FAIL redir_instr pc=%h data=%h exp_pc=%h", obs_pc[k], obs_data[k], e); end
        end
    endtask

    task automatic test_drain_redirect();
        logic [31:0] e;
        do_reset();
        lat = 4; mem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (2) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_pc = 32'h80;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL drain2_req got=%b exp=0", mem_req_valid); end
        clear_logs();
        for (int k = 0; k < 8; k++) exp_pc.push_back(32'h80 + 32'(k * 4));
        repeat (16) cycle();
        checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h80) begin failures++; $display("FAIL drain2_first_req exp=00000080 n=%0d", acc_q.size()); end
        checks++; if (obs_pc.size() < 3) begin failures++; $display("FAIL drain2_count got=%0d exp>=3", obs_pc.size()); end
        for (int k = 0; k < obs_pc.size() && exp_pc.size() > 0; k++) begin
            e = exp_pc.pop_front();
            checks++; if (obs_pc[k] !== e || obs_data[k] !== memfn(e)) begin failures++; $display("FAIL drain2_instr pc=%h exp=%h", obs_pc[k], e); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1; mem_req_ready = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin failures++; $display("FAIL stall_hold v=%b addr=%h exp v=1 addr=0", mem_req_valid, mem_req_addr); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_instr_valid got=%b exp=0", instr_valid); end
        end
        mem_req_ready = 1'b1;
        repeat (6) cycle();
        checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h0) begin failures++; $display("FAIL stall_resume_req n=%0d exp first=0", acc_q.size()); end
        checks++; if (obs_pc.size() == 0 || obs_pc[0] !== 32'h0 || obs_data[0] !== memfn(32'h0)) begin failures++; $display("FAIL stall_resume_instr n=%0d exp pc=0", obs_pc.size()); end
    endtask

    task automatic test_stray();
        do_reset();
        lat = 1; mem_req_ready = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEADBEEF;
            cycle();
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stray_ignored got=%b exp=0", instr_valid); end
        end
        mem_req_ready = 1'b1;
        repeat (5) cycle();
        checks++; if (obs_pc.size() < 2 || obs_pc[0] !== 32'h0 || obs_data[0] !== memfn(32'h0) || obs_pc[1] !== 32'h4) begin failures++; $display("FAIL stray_then_stream n=%0d exp pcs 0,4", obs_pc.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 3; mem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (2) cycle();
        do_reset();
        lat = 3; mem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (10) cycle();
        checks++; if (obs_pc.size() < 3 || obs_pc[0] !== 32'h0 || obs_pc[1] !== 32'h4 || obs_pc[2] !== 32'h8) begin failures++; $display("FAIL midreset_stream n=%0d exp pcs 0,4,8", obs_pc.size()); end
        checks++; if (obs_data.size() == 0 || obs_data[0] !== memfn(32'h0)) begin failures++; $display("FAIL midreset_data exp=%h", memfn(32'h0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        checks++; if (w_valid !== 1'b1 || w_addr !== 32'hFFFFFFF8) begin failures++; $display("FAIL wrap0 v=%b addr=%h exp fffffff8", w_valid, w_addr); end
        cycle();
        checks++; if (w_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap1 addr=%h exp fffffffc", w_addr); end
        cycle();
        checks++; if (w_addr !== 32'h00000000) begin failures++; $display("FAIL wrap2 addr=%h exp 00000000", w_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_drain_redirect();
        test_stall();
        test_stray();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning data and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch credit count (power of 2, range 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low: state is reset on a rising clk edge when rst==0.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 SHALL have port redirect_pc  input  WORD_SIZE  new fetch target.
REQ-008 SHALL have port mem_req_valid  output  1  fetch request to instruction memory.
REQ-009 SHALL have port mem_req_addr  output  WORD_SIZE  fetch address.
REQ-010 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-011 SHALL have port mem_resp_valid  input  1  in-order response present; responses arrive at least 1 cycle after acceptance.
REQ-012 SHALL have port mem_resp_data  input  WORD_SIZE  fetched instruction word.
REQ-013 SHALL have port instr_valid  output  1  queue head valid toward processor.
REQ-014 SHALL have port instr_data  output  WORD_SIZE  head instruction.
REQ-015 SHALL have port instr_pc  output  WORD_SIZE  address of head instruction.
REQ-016 SHALL have port instr_ready  input  1  processor consumes head.

Function
REQ-017 SHALL hold fetch_pc, a FIFO of DEPTH {pc,data} entries, an outstanding counter (0..DEPTH), a drop counter (0..DEPTH), and a 2-state FSM {FETCH, DRAIN}.
REQ-018 SHALL assert mem_req_valid only when FSM==FETCH, rst==1, and occupancy+outstanding < DEPTH; mem_req_addr SHALL equal fetch_pc.
REQ-019 SHALL count a request accepted when mem_req_valid && mem_req_ready; fetch_pc SHALL then advance by 4 modulo 2^WORD_SIZE (32'hFFFFFFFC wraps to 0).
REQ-020 SHALL keep mem_req_valid and mem_req_addr stable while mem_req_ready is low, unless a redirect occurs.
REQ-021 SHALL, in FETCH, push each response into the FIFO with its PC (tracked in-order, issue order); instr_valid SHALL rise the cycle after the push (1-cycle response-to-output latency).
REQ-022 SHALL pop the FIFO on instr_valid && instr_ready; push and pop in the same cycle SHALL both occur, including when full.
REQ-023 SHALL drive instr_data and instr_pc to 0 when the FIFO is empty.
REQ-024 SHALL, on redirect_valid: flush the FIFO; set fetch_pc = {redirect_pc[WORD_SIZE-1:2],2'b00}; set drop = outstanding requests not yet answered, including one accepted and excluding one answered in the same cycle; go to DRAIN if drop>0, else FETCH.
REQ-025 SHALL treat a handshake on instr_valid/instr_ready in the redirect cycle as consumed; a response in the redirect cycle SHALL be discarded.
REQ-026 SHALL, in DRAIN, issue no requests, discard every response, decrement drop per response, and enter FETCH the cycle after drop reaches 0.
REQ-027 SHALL, on redirect while in DRAIN, update fetch_pc and remain in DRAIN with drop recomputed per REQ-024.
REQ-028 SHALL never overflow the FIFO: a response arriving when no outstanding request exists SHALL be ignored.

Reset
REQ-029 SHALL, while rst==0 at a clk edge: FSM=FETCH, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
REQ-030 SHALL drive mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0 and mem_req_addr=RESET_PC during reset; the first request SHALL be presented in the first cycle with rst==1.
REQ-031 SHALL discard responses from requests issued before a mid-operation reset; the memory model is reset in the same cycle.

Verification
REQ-032 Reset release, ready always 1, resp latency 1, instr_ready=1 -> requests at 0x0,0x4,0x8..., instr_pc stream 0x0,0x4,0x8 at 1/cycle after 2-cycle fill.
REQ-033 instr_ready=0, memory always ready -> exactly DEPTH=4 requests (0x0..0xC), then mem_req_valid=0; instr_valid=1 with instr_pc=0x0 held.
REQ-034 Redirect to 0x103 with 2 responses outstanding -> FIFO empty next cycle, next 2 responses dropped, then request at 0x100, instr_pc=0x100.
REQ-035 Redirect to 0x40 while in DRAIN, then redirect to 0x80 -> only 0x80 is fetched after drain; no 0x40 instruction is visible.
REQ-036 RESET_PC=32'hFFFFFFF8, 3 fetches -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 mem_req_ready low for 5 cycles -> mem_req_addr held constant, outstanding unchanged, no spurious instr_valid.
